quad_decoder: RTL and testbench
===============================

# quad_decoder

Quadrature input decoder that drives the position/counting path. It synchronizes and glitch-filters two asynchronous encoder phases (A/B) and decodes Gray-code transitions into a one-cycle step pulse plus a direction flag. It also maintains a wrapping position counter with terminal-count flag, sourcing the enable/up_down style stimulus that the team's up/down counters consume.

## Interface
- END_COUNT, default 360: position modulus; position range 0..END_COUNT-1; must be ≥ 2.
- FILTER_LEN, default 3: consecutive clocks a synchronized phase must hold a new level before acceptance; must be ≥ 1.
- N (derived): ceil(log2(END_COUNT)), minimum 1; position width.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low.
- a_in  input  1  encoder phase A, asynchronous.
- b_in  input  1  encoder phase B, asynchronous.
- enable  input  1  1 = steps update position; 0 = position frozen.
- load  input  1  synchronous load of position.
- load_val  input  N  value for load; values ≥ END_COUNT are clamped to END_COUNT-1.
- clear_err  input  1  clears err_flag.
- step  output  1  one-cycle pulse per accepted valid transition while enable=1.
- dir  output  1  1 = last valid transition forward (up), 0 = reverse (down).
- pos  output  N  position.
- tc  output  1  terminal count, combinational from dir and pos.
- err  output  1  one-cycle pulse on illegal transition.
- err_flag  output  1  sticky error.

## Operation
- Synchronizer: two flops per phase (s1, s2); reset value 0.
- Filter, per phase: counter increments while s2 ≠ filtered value and clears when they are equal. The filtered value takes s2 on the edge where s2 has differed for FILTER_LEN consecutive edges, including that edge.
- State machine:
  - INIT, entered on reset: filtered {A,B} is adopted as the baseline; no step/err generated. Moves to TRACK once both phases have been stable, meaning s2 unchanged, for FILTER_LEN consecutive edges.
  - TRACK: compare previous and current filtered {A,B}.
- Forward sequence: 00→01→11→10→00. Reverse is the opposite order.
- Transition classes:
  - Forward: step=1 (if enable), dir←1, pos+1.
  - Reverse: step=1 (if enable), dir←0, pos−1.
  - Both bits changed: err=1, err_flag←1, dir/pos unchanged, no step.
  - No change: nothing.
- Previous-state register updates on every filtered change regardless of enable, so re-enabling causes no spurious step. Direction updates even when enable=0.
- Wrap-around: up from END_COUNT-1 gives 0; down from 0 gives END_COUNT-1. No other arithmetic overflow is possible.
- tc = (dir && pos == END_COUNT-1) || (!dir && pos == 0).
- Priority on pos: reset > load > step. When load and a step coincide, pos = load_val (clamped), but step/dir/err still reflect the transition.
- err_flag: set beats clear_err in the same cycle.
- Reset values: pos=0, dir=1, step=0, err=0, err_flag=0, filters/synchronizers 0, state INIT. tc therefore reads 0 during reset (dir=1, pos=0, END_COUNT ≥ 2).
- Reset asserted mid-operation: all state returns to reset values at the next edge; in-progress filter counts are discarded.

## Timing
- Phase change stable before sampling edge E1:
  - s1 at E1, s2 at E2.
  - Filtered value at E(FILTER_LEN+1).
  - step/err/dir/pos registered at E(FILTER_LEN+2). Default: E5.
- step and err are high for exactly one cycle per transition.
- Maximum accepted transition rate: one per FILTER_LEN+1 clocks per phase. Faster glitches are rejected silently, with no err.
- load: pos = load_val after the edge at which load=1; one-cycle latency.
- clear_err: err_flag low after that edge unless a new error is registered on the same edge.
- tc follows pos/dir combinationally, with no added latency.

## Test plan
- Reset, inputs held at 11 for 10 clocks: no step, no err; state reaches TRACK; pos=0, dir=1, tc=0.
- From baseline 00, apply forward sequence 01,11,10,00 spaced 8 clocks apart, enable=1 (FILTER_LEN=3): four step pulses, each 5 edges after its input change; pos 0→4; dir=1.
- From pos=0, one reverse transition: pos=359, dir=0, tc=0. Then load=1 with load_val=0: pos=0, tc=1. Then load_val=500: pos=359.
- Glitch test: a 2-clock pulse on a_in (FILTER_LEN=3): no filtered change, no step, pos unchanged.
- Illegal transition 00→11: err pulse for one cycle, err_flag=1, pos unchanged. clear_err asserted on the same cycle as a second illegal transition: err_flag stays 1. clear_err alone on a later cycle: err_flag=0.
- With enable=0, three forward transitions: no step, pos held, dir=1. Set enable=1 and make one more forward transition: exactly one step, pos+1. Assert reset mid-sequence: all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: synchronizes and glitch-filters phases A/B,
// decodes Gray-code steps into step/dir pulses and keeps a wrapping position.
module quad_decoder #(
    parameter int END_COUNT  = 360,
    parameter int FILTER_LEN = 3,
    localparam int N = (END_COUNT > 2) ? $clog2(END_COUNT) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_in,
    input  logic         b_in,
    input  logic         enable,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         clear_err,
    output logic         step,
    output logic         dir,
    output logic [N-1:0] pos,
    output logic         tc,
    output logic         err,
    output logic         err_flag
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [N-1:0]  POS_MAX  = N'(END_COUNT - 1);

    typedef enum logic {ST_INIT, ST_TRACK} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync1_q, sync1_d;
    logic [1:0]           sync2_q, sync2_d;
    logic [1:0]           filt_q, filt_d;
    logic [1:0]           prev_q, prev_d;
    logic [1:0][CW-1:0]   fcnt_q, fcnt_d;
    logic [CW-1:0]        stab_q, stab_d;
    logic                 step_q, step_d;
    logic                 dir_q, dir_d;
    logic                 err_q, err_d;
    logic                 err_flag_q, err_flag_d;
    logic [N-1:0]         pos_q, pos_d;
    logic [N-1:0]         pos_inc, pos_dec, load_clamped;
    logic [1:0]           delta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            fcnt_q     <= '0;
            stab_q     <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b1;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            fcnt_q     <= fcnt_d;
            stab_q     <= stab_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
            pos_q      <= pos_d;
        end
    end

    always_comb begin
        sync1_d = {a_in, b_in};
        sync2_d = sync1_q;
        // sync1_q is the value s2 takes on this edge, so that edge counts toward acceptance
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync1_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == CNT_LAST) filt_d[i] = sync1_q[i];
                else                       fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end

        prev_d  = filt_q;
        state_d = state_q;
        stab_d  = '0;
        if (state_q == ST_INIT && sync1_q == sync2_q) begin
            if (stab_q == CNT_LAST) state_d = ST_TRACK;
            else                    stab_d  = stab_q + 1'b1;
        end

        pos_inc      = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
        pos_dec      = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
        load_clamped = (load_val > POS_MAX) ? POS_MAX : load_val;

        // Gray -> binary makes forward +1, reverse -1 and a double-bit change +2 (mod 4)
        delta = {filt_q[1], ^filt_q} - {prev_q[1], ^prev_q};

        step_d     = 1'b0;
        err_d      = 1'b0;
        dir_d      = dir_q;
        pos_d      = pos_q;
        err_flag_d = clear_err ? 1'b0 : err_flag_q;
        if (state_q == ST_TRACK) begin
            case (delta)
                2'd1: begin
                    dir_d  = 1'b1;
                    step_d = enable;
                    if (enable) pos_d = pos_inc;
                end
                2'd3: begin
                    dir_d  = 1'b0;
                    step_d = enable;
                    if (enable) pos_d = pos_dec;
                end
                2'd2: begin
                    err_d      = 1'b1;
                    err_flag_d = 1'b1;
                end
                default: ;
            endcase
        end
        if (load) pos_d = load_clamped;
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign pos      = pos_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;
    assign tc       = (dir_q && pos_q == POS_MAX) || (!dir_q && pos_q == '0);

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus random phase moves, with a
// queue-based scoreboard matching each step/err pulse against a position model.
module tb_quad_decoder;

    localparam int EC  = 360;
    localparam int FL  = 3;
    localparam int N   = 9;
    localparam int LAT = FL + 2;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         a_in = 1'b0, b_in = 1'b0;
    logic         enable = 1'b1, load = 1'b0, clear_err = 1'b0;
    logic [N-1:0] load_val = '0;
    logic         step, dir, tc, err, err_flag;
    logic [N-1:0] pos;

    quad_decoder #(.END_COUNT(EC), .FILTER_LEN(FL)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .enable(enable),
        .load(load), .load_val(load_val), .clear_err(clear_err),
        .step(step), .dir(dir), .pos(pos), .tc(tc), .err(err), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_err;
        bit dir;
        int pos;
        bit eflag;
    } exp_t;

    exp_t     q[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;

    // Model state: index into the forward Gray cycle, plus expected outputs
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int  idx = 0;
    int  m_pos = 0;
    bit  m_dir = 1'b1;
    bit  m_eflag = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic bit model_tc();
        return (m_dir && m_pos == EC - 1) || (!m_dir && m_pos == 0);
    endfunction

    // Monitor: every step/err pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (reset && (step || err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event step=%0b err=%0b pos=%0d, expected no event", step, err, pos);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("evt_cycle", cyc, e.cyc);
                chk("evt_step", int'(step), int'(!e.is_err));
                chk("evt_err", int'(err), int'(e.is_err));
                chk("evt_dir", int'(dir), int'(e.dir));
                chk("evt_pos", int'(pos), e.pos);
                chk("evt_err_flag", int'(err_flag), int'(e.eflag));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind: 1 forward, 3 reverse, 2 both bits flip
    task automatic issue(input int kind);
        exp_t e;
        idx = (idx + kind) % 4;
        {a_in, b_in} = gray[idx];
        if (kind == 2) begin
            m_eflag = 1'b1;
            e = '{cyc + LAT, 1'b1, m_dir, m_pos, 1'b1};
            q.push_back(e);
        end else begin
            m_dir = (kind == 1);
            if (enable) begin
                m_pos = (kind == 1) ? (m_pos + 1) % EC : (m_pos + EC - 1) % EC;
                e = '{cyc + LAT, 1'b0, m_dir, m_pos, m_eflag};
                q.push_back(e);
            end
        end
    endtask

    task automatic do_load(input int val);
        logic [N-1:0] v;
        v = val[N-1:0];
        load = 1'b1;
        load_val = v;
        wait_cyc(1);
        load = 1'b0;
        m_pos = (int'(v) > EC - 1) ? EC - 1 : int'(v);
        chk("load_pos", int'(pos), m_pos);
        chk("load_tc", int'(tc), int'(model_tc()));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_pos"}, int'(pos), m_pos);
        chk({tag, "_dir"}, int'(dir), int'(m_dir));
        chk({tag, "_tc"}, int'(tc), int'(model_tc()));
        chk({tag, "_err_flag"}, int'(err_flag), int'(m_eflag));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_dir"}, int'(dir), 1);
        chk({tag, "_tc"}, int'(tc), 0);
        chk({tag, "_step"}, int'(step), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_flag"}, int'(err_flag), 0);
    endtask

    task automatic apply_reset(input int start_idx);
        reset = 1'b0;
        idx = start_idx;
        {a_in, b_in} = gray[idx];
        wait_cyc(2);
        q.delete();
        m_pos = 0;
        m_dir = 1'b1;
        m_eflag = 1'b0;
        check_reset_values("in_reset");
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        wait_cyc(1);

        // Reset with inputs at 11, then idle: baseline adopted, no events
        apply_reset(2);
        wait_cyc(10);
        check_state("after_init");
        issue(1);
        wait_cyc(8);
        check_state("first_track_step");

        // Forward sweep from a 00 baseline
        apply_reset(0);
        wait_cyc(10);
        for (int i = 0; i < 4; i++) begin
            issue(1);
            wait_cyc(8);
        end
        check_state("fwd_sweep");

        // Reverse wrap and load clamping
        do_load(0);
        issue(3);
        wait_cyc(8);
        check_state("rev_wrap");
        do_load(0);
        do_load(500);

        // Short pulse on A must be filtered out
        a_in = ~a_in;
        wait_cyc(2);
        a_in = ~a_in;
        wait_cyc(10);
        check_state("glitch");

        // Illegal transitions and sticky flag handling
        issue(2);
        wait_cyc(8);
        check_state("illegal1");
        issue(2);
        wait_cyc(LAT - 1);
        clear_err = 1'b1;
        wait_cyc(1);
        clear_err = 1'b0;
        chk("set_beats_clear", int'(err_flag), 1);
        wait_cyc(3);
        clear_err = 1'b1;
        wait_cyc(1);
        clear_err = 1'b0;
        m_eflag = 1'b0;
        chk("clear_err_alone", int'(err_flag), 0);

        // Disabled steps still move direction but not position
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(1);
            wait_cyc(8);
        end
        check_state("disabled");
        enable = 1'b1;
        issue(1);
        wait_cyc(8);
        check_state("reenabled");

        // Load coinciding with a step: load wins on pos, step still reported
        issue(1);
        q[q.size() - 1].pos = 100;
        wait_cyc(LAT - 1);
        load = 1'b1;
        load_val = 9'd100;
        wait_cyc(1);
        load = 1'b0;
        m_pos = 100;
        wait_cyc(3);
        check_state("load_vs_step");

        // Randomized moves, glitches and loads
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 9);
            enable = ($urandom_range(0, 3) != 0);
            if (r <= 3) begin
                issue(1);
                wait_cyc(8);
            end else if (r <= 6) begin
                issue(3);
                wait_cyc(8);
            end else if (r == 7) begin
                issue(2);
                wait_cyc(8);
            end else if (r == 8) begin
                int w;
                w = $urandom_range(1, FL - 1);
                if ($urandom_range(0, 1) == 1) a_in = ~a_in; else b_in = ~b_in;
                wait_cyc(w);
                {a_in, b_in} = gray[idx];
                wait_cyc(8);
            end else begin
                do_load(int'($urandom_range(0, 511)));
            end
            check_state("rand");
        end
        enable = 1'b1;

        // Reset in the middle of a pending transition
        issue(2);
        wait_cyc(8);
        issue(3);
        wait_cyc(8);
        issue(1);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        q.delete();
        m_pos = 0;
        m_dir = 1'b1;
        m_eflag = 1'b0;
        check_reset_values("mid_reset");
        reset = 1'b1;
        wait_cyc(10);
        check_state("post_reset_idle");
        issue(3);
        wait_cyc(8);
        check_state("post_reset_step");

        for (int i = 0; i < 50 && q.size() != 0; i++) wait_cyc(1);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
